// File: rtl/dram_arbiter_if.sv
// Bus bundle between two requesting ports, the arbiter and the dRam.
// The arbiter connects through the slave modport; requesters and the
// memory model connect through the master modport.
interface dram_arbiter_if #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 8
);
    logic              a_req;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_ack;
    logic [DATA_W-1:0] a_rdata;

    logic              b_req;
    logic              b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic              b_ack;
    logic [DATA_W-1:0] b_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [1:0]        mem_write;
    logic [DATA_W-1:0] mem_dout;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        output a_ack, a_rdata,
        input  b_req, b_we, b_addr, b_wdata,
        output b_ack, b_rdata,
        output mem_addr, mem_din, mem_write,
        input  mem_dout
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        input  a_ack, a_rdata,
        output b_req, b_we, b_addr, b_wdata,
        input  b_ack, b_rdata,
        input  mem_addr, mem_din, mem_write,
        output mem_dout
    );
endinterface

// File: rtl/dram_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported dRam.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for a request; grants and latches the winner
//   RD_ADDR | read address on mem_addr
//   RD_WAIT | dRam data valid on mem_dout, captured into owner's rdata
//   WR      | mem_write = 2'b10 for WR_CYCLES cycles (down-counter)
//   ACK     | one-cycle ack to the owner, then back to IDLE
//
// All outputs are registered from the next state so they line up with the
// state they belong to: ack is high exactly while the FSM is in ACK.
module dram_arbiter #(
    parameter int ADDR_W    = 19,
    parameter int DATA_W    = 8,
    parameter int WR_CYCLES = 2
) (
    input  logic         clk,
    input  logic         reset,
    dram_arbiter_if.slave bus
);

    localparam int CNT_W = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WR_CYCLES - 1);

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_WAIT = 3'd2,
        WR      = 3'd3,
        ACK     = 3'd4
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              owner;
    logic              last_grant;
    logic [CNT_W-1:0]  wr_cnt;

    logic              grant;
    logic              grant_port;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // Next-state logic and grant arbitration (round-robin on a tie).
    always_comb begin
        state_nxt  = state;
        grant      = 1'b0;
        grant_port = last_grant;
        sel_we     = 1'b0;
        sel_addr   = bus.a_addr;
        sel_wdata  = bus.a_wdata;

        case (state)
            IDLE: begin
                if (bus.a_req || bus.b_req) begin
                    grant = 1'b1;
                    if (bus.a_req && bus.b_req) begin
                        grant_port = ~last_grant;
                    end else begin
                        grant_port = bus.b_req ? PORT_B : PORT_A;
                    end
                    if (grant_port == PORT_B) begin
                        sel_we    = bus.b_we;
                        sel_addr  = bus.b_addr;
                        sel_wdata = bus.b_wdata;
                    end else begin
                        sel_we    = bus.a_we;
                        sel_addr  = bus.a_addr;
                        sel_wdata = bus.a_wdata;
                    end
                    state_nxt = sel_we ? WR : RD_ADDR;
                end
            end
            RD_ADDR: state_nxt = RD_WAIT;
            RD_WAIT: state_nxt = ACK;
            WR: begin
                if (wr_cnt == '0) begin
                    state_nxt = ACK;
                end
            end
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State, arbitration history and write-length counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= PORT_A;
            last_grant <= PORT_B;
            wr_cnt     <= '0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                owner      <= grant_port;
                last_grant <= grant_port;
            end
            if (grant && sel_we) begin
                wr_cnt <= CNT_LOAD;
            end else if (state == WR && wr_cnt != '0) begin
                wr_cnt <= wr_cnt - 1'b1;
            end
        end
    end

    // Registered dRam and port outputs; mem_addr/mem_din double as the
    // transaction latch, so later port changes cannot disturb it.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.mem_addr  <= '0;
            bus.mem_din   <= '0;
            bus.mem_write <= 2'b00;
            bus.a_ack     <= 1'b0;
            bus.b_ack     <= 1'b0;
            bus.a_rdata   <= '0;
            bus.b_rdata   <= '0;
        end else begin
            if (grant) begin
                bus.mem_addr <= sel_addr;
                if (sel_we) begin
                    bus.mem_din <= sel_wdata;
                end
            end
            bus.mem_write <= (state_nxt == WR) ? 2'b10 : 2'b00;
            bus.a_ack     <= (state_nxt == ACK) && (owner == PORT_A);
            bus.b_ack     <= (state_nxt == ACK) && (owner == PORT_B);
            if (state == RD_WAIT) begin
                if (owner == PORT_B) begin
                    bus.b_rdata <= bus.mem_dout;
                end else begin
                    bus.a_rdata <= bus.mem_dout;
                end
            end
        end
    end

endmodule

// File: tb/tb_dram_arbiter.sv
// Bench for dram_arbiter: a directed vector table, randomized rounds scored
// against a transaction-level model, and hand sequences for alternation,
// reset mid-write and the post-reset idle state.
module tb_dram_arbiter;
    localparam int ADDR_W    = 19;
    localparam int DATA_W    = 8;
    localparam int WR_CYCLES = 2;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    dram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

    dram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WR_CYCLES(WR_CYCLES)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [7:0] init_val(input int i);
        return 8'((i * 7 + 3) & 255);
    endfunction

    // Behavioural dRam: synchronous read (data the cycle after the address),
    // writes while mem_write is 2'b10, contents re-seeded during reset.
    logic [7:0] dram [256];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) dram[i] <= init_val(i);
        end else if (bus.mem_write == 2'b10) begin
            dram[bus.mem_addr[7:0]] <= bus.mem_din;
        end
        bus.mem_dout <= dram[bus.mem_addr[7:0]];
    end

    // Reference model state
    logic [7:0] ref_mem [256];
    logic [7:0] rd_m [2];
    bit         lg_m;
    int         n_cmp = 0;
    int         n_bad = 0;

    typedef struct {
        bit do_reset;
        bit a_en; bit a_we; int a_addr; int a_wd;
        bit b_en; bit b_we; int b_addr; int b_wd;
        bit exp_first; int exp_ard; int exp_brd;
    } vec_t;

    vec_t tab [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lat(input bit we);
        return we ? WR_CYCLES + 1 : 3;
    endfunction

    function automatic vec_t mk(input bit rst,
                                input bit ae, input bit aw, input int aa, input int ad,
                                input bit be, input bit bw, input int ba, input int bd,
                                input bit f, input int ar, input int br);
        vec_t v;
        v.do_reset = rst;
        v.a_en = ae; v.a_we = aw; v.a_addr = aa; v.a_wd = ad;
        v.b_en = be; v.b_we = bw; v.b_addr = ba; v.b_wd = bd;
        v.exp_first = f; v.exp_ard = ar; v.exp_brd = br;
        return v;
    endfunction

    task automatic set_port(input int p, input bit req, input bit we, input int addr, input int wd);
        if (p == 0) begin
            bus.a_req = req; bus.a_we = we;
            bus.a_addr = ADDR_W'(addr); bus.a_wdata = DATA_W'(wd);
        end else begin
            bus.b_req = req; bus.b_we = we;
            bus.b_addr = ADDR_W'(addr); bus.b_wdata = DATA_W'(wd);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        rd_m[0] = 8'h00;
        rd_m[1] = 8'h00;
        lg_m = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        set_port(0, 0, 0, 0, 0);
        set_port(1, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    // One arbitration round: raise the enabled requests together in an idle
    // cycle, then check every cycle against the schedule the model derives.
    task automatic run_round(input vec_t v, output bit first);
        bit en [2]; bit we [2]; int addr [2]; int wd [2];
        int g [2]; int ak [2];
        bit second; bit both; int last; bit exp_mw;
        en[0] = v.a_en; we[0] = v.a_we; addr[0] = v.a_addr; wd[0] = v.a_wd;
        en[1] = v.b_en; we[1] = v.b_we; addr[1] = v.b_addr; wd[1] = v.b_wd;
        first = 1'b0;
        if (!en[0] && !en[1]) return;
        both   = en[0] && en[1];
        first  = both ? ~lg_m : en[1];
        second = ~first;
        g[first]  = 0;
        ak[first] = lat(we[first]);
        if (both) begin
            g[second]  = ak[first] + 1;
            ak[second] = g[second] + lat(we[second]);
        end else begin
            g[second]  = -100;
            ak[second] = -100;
        end
        last = both ? ak[second] : ak[first];
        lg_m = both ? second : first;

        @(negedge clk);
        for (int p = 0; p < 2; p++) set_port(p, en[p], we[p], addr[p], wd[p]);

        for (int k = 1; k <= last; k++) begin
            @(negedge clk);
            chk("a_ack", {31'd0, bus.a_ack}, {31'd0, k == ak[0]});
            chk("b_ack", {31'd0, bus.b_ack}, {31'd0, k == ak[1]});
            exp_mw = 1'b0;
            for (int p = 0; p < 2; p++) begin
                if (en[p] && we[p] && k > g[p] && k <= g[p] + WR_CYCLES) begin
                    exp_mw = 1'b1;
                    chk("wr_mem_addr", 32'(bus.mem_addr), 32'(addr[p]));
                    chk("wr_mem_din", 32'(bus.mem_din), 32'(wd[p] & 255));
                end
                if (en[p] && !we[p] && k == g[p] + 1)
                    chk("rd_mem_addr", 32'(bus.mem_addr), 32'(addr[p]));
            end
            chk("mem_write", 32'(bus.mem_write), exp_mw ? 32'd2 : 32'd0);
            for (int p = 0; p < 2; p++) begin
                if (en[p] && k == ak[p]) begin
                    if (we[p]) ref_mem[addr[p]] = 8'(wd[p]);
                    else       rd_m[p] = ref_mem[addr[p]];
                    chk("a_rdata", 32'(bus.a_rdata), 32'(rd_m[0]));
                    chk("b_rdata", 32'(bus.b_rdata), 32'(rd_m[1]));
                    set_port(p, 0, 0, 0, 0);
                end else if (en[p] && k > g[p] && k < ak[p]) begin
                    set_port(p, 1, 1'($urandom_range(0, 1)), addr[p] + 1, int'($urandom_range(0, 255)));
                end
            end
        end
    endtask

    initial begin
        bit f;
        vec_t rv;
        int order [$];
        bit pend [2];

        reset = 1'b1;
        set_port(0, 0, 0, 0, 0);
        set_port(1, 0, 0, 0, 0);
        model_reset();

        // init_val: 1->10, 2->17, 3->24, 4->31, 5->38, 10->73
        tab[0] = mk(1, 1,1,4,20,   0,0,0,0,    0, 0,  0);
        tab[1] = mk(0, 1,0,4,0,    0,0,0,0,    0, 20, 0);
        tab[2] = mk(1, 1,0,1,0,    1,0,2,0,    0, 10, 17);
        tab[3] = mk(0, 1,0,3,0,    1,0,5,0,    0, 24, 38);
        tab[4] = mk(0, 1,0,5,0,    1,1,5,99,   0, 38, 38);
        tab[5] = mk(0, 0,0,0,0,    1,0,5,0,    1, 38, 99);
        tab[6] = mk(0, 1,1,6,7,    1,0,6,0,    0, 38, 7);
        tab[7] = mk(0, 1,0,10,0,   0,0,0,0,    0, 73, 7);
        tab[8] = mk(0, 0,0,0,0,    1,0,4,0,    1, 73, 31);

        // Reset then idle: every output at zero, no ack.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_a_ack", {31'd0, bus.a_ack}, 32'd0);
            chk("idle_b_ack", {31'd0, bus.b_ack}, 32'd0);
            chk("idle_a_rdata", 32'(bus.a_rdata), 32'd0);
            chk("idle_b_rdata", 32'(bus.b_rdata), 32'd0);
            chk("idle_mem_addr", 32'(bus.mem_addr), 32'd0);
            chk("idle_mem_din", 32'(bus.mem_din), 32'd0);
            chk("idle_mem_write", 32'(bus.mem_write), 32'd0);
        end

        // Directed table
        for (int i = 0; i < 9; i++) begin
            if (tab[i].do_reset) do_reset();
            run_round(tab[i], f);
            chk("tab_first", {31'd0, f}, {31'd0, tab[i].exp_first});
            chk("tab_a_rdata", 32'(bus.a_rdata), 32'(tab[i].exp_ard));
            chk("tab_b_rdata", 32'(bus.b_rdata), 32'(tab[i].exp_brd));
        end

        // Continuous re-request from both ports: grants alternate A,B,...
        do_reset();
        @(negedge clk);
        set_port(0, 1, 0, 20, 0);
        set_port(1, 1, 0, 21, 0);
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        for (int c = 0; c < 80 && order.size() < 8; c++) begin
            @(negedge clk);
            chk("ack_overlap", {31'd0, bus.a_ack & bus.b_ack}, 32'd0);
            for (int p = 0; p < 2; p++) begin
                if (pend[p]) begin
                    set_port(p, 1, 0, 20 + p, 0);
                    pend[p] = 1'b0;
                end
            end
            if (bus.a_ack) begin order.push_back(0); set_port(0, 0, 0, 20, 0); pend[0] = 1'b1; end
            if (bus.b_ack) begin order.push_back(1); set_port(1, 0, 0, 21, 0); pend[1] = 1'b1; end
        end
        set_port(0, 0, 0, 0, 0);
        set_port(1, 0, 0, 0, 0);
        chk("alt_count", 32'(order.size()), 32'd8);
        for (int i = 0; i < order.size(); i++)
            chk("alt_order", 32'(order[i]), 32'(i % 2));

        // B write aborted by reset in its first WR cycle.
        do_reset();
        @(negedge clk);
        set_port(1, 1, 1, 30, 55);
        @(negedge clk);
        chk("abort_wr_started", 32'(bus.mem_write), 32'd2);
        reset = 1'b1;
        set_port(1, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        chk("abort_mem_write", 32'(bus.mem_write), 32'd0);
        chk("abort_b_ack", {31'd0, bus.b_ack}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("abort_b_ack_later", {31'd0, bus.b_ack}, 32'd0);
            chk("abort_mem_write_later", 32'(bus.mem_write), 32'd0);
        end
        run_round(mk(0, 1,0,30,0, 0,0,0,0, 0, 213, 0), f);
        chk("abort_then_read", 32'(bus.a_rdata), 32'd213);

        // Randomized rounds against the model
        do_reset();
        for (int r = 0; r < 40; r++) begin
            int sel;
            int gap;
            sel = int'($urandom_range(1, 3));
            rv = mk(0,
                    sel[0], 1'($urandom_range(0, 1)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                    sel[1], 1'($urandom_range(0, 1)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                    0, 0, 0);
            gap = int'($urandom_range(0, 2));
            for (int i = 0; i < gap; i++) begin
                @(negedge clk);
                chk("gap_a_ack", {31'd0, bus.a_ack}, 32'd0);
                chk("gap_b_ack", {31'd0, bus.b_ack}, 32'd0);
                chk("gap_mem_write", 32'(bus.mem_write), 32'd0);
            end
            run_round(rv, f);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/dram_arbiter.md
DRAM_ARBITER -- requirements
Module: dram_arbiter

Interface
REQ-001: Parameter ADDR_W, default 19, SHALL be the dRam address width.
REQ-002: Parameter DATA_W, default 8, SHALL be the dRam data width.
REQ-003: Parameter WR_CYCLES, default 2, SHALL be the cycles mem_write is held at 2'b10 per write.
REQ-004: clk  in  1  SHALL be the single clock; all state updates on rising edge.
REQ-005: reset  in  1  SHALL be a synchronous, active-high reset.
REQ-006: a_req  in  1  SHALL be port A request, held high until a_ack.
REQ-007: a_we  in  1  SHALL select port A write (1) or read (0).
REQ-008: a_addr  in  ADDR_W  SHALL be the port A address.
REQ-009: a_wdata  in  DATA_W  SHALL be the port A write data.
REQ-010: a_ack  out  1  SHALL be the port A one-cycle completion pulse.
REQ-011: a_rdata  out  DATA_W  SHALL be the port A last read data.
REQ-012: b_req, b_we, b_addr, b_wdata, b_ack, b_rdata SHALL be port B equivalents of REQ-006..011.
REQ-013: mem_addr  out  ADDR_W  SHALL drive dRam dAddr.
REQ-014: mem_din  out  DATA_W  SHALL drive dRam d_in.
REQ-015: mem_write  out  2  SHALL drive dRam MEM_WRITE (2'b10 write, 2'b00 idle/read).
REQ-016: mem_dout  in  DATA_W  SHALL be dRam d_out.

Function
REQ-017: All outputs SHALL be registered.
REQ-018: FSM states SHALL be IDLE, RD_ADDR, RD_WAIT, WR, ACK.
REQ-019: In IDLE with any req high, block SHALL latch owner, we, addr, wdata and go to RD_ADDR (we=0) or WR (we=1).
REQ-020: Only one request in IDLE SHALL grant that port; both SHALL grant the port not in last_grant register.
REQ-021: last_grant SHALL update to the granted port at every grant.
REQ-022: RD_ADDR: mem_addr = latched addr, mem_write = 2'b00, then RD_WAIT.
REQ-023: dRam read data SHALL be valid on mem_dout the cycle after mem_addr is presented.
REQ-024: RD_WAIT: capture mem_dout into owner's rdata register at end of cycle, then ACK.
REQ-025: WR: mem_addr = latched addr, mem_din = latched wdata, mem_write = 2'b10 for exactly WR_CYCLES cycles (counter), then ACK.
REQ-026: ACK: owner's ack = 1 for exactly one cycle, mem_write = 2'b00, then IDLE unconditionally.
REQ-027: Non-owner ack SHALL stay 0; non-owner rdata SHALL be unchanged.
REQ-028: Latency from grant edge to ack high: read 3 cycles, write WR_CYCLES+1 cycles.
REQ-029: mem_addr and mem_din SHALL hold their last values in IDLE and ACK; mem_write SHALL be 2'b00 outside WR.
REQ-030: Requester SHALL deassert req in the cycle after ack; req high in IDLE is a new request.
REQ-031: Port changes to addr/we/wdata after grant SHALL NOT affect the transaction in progress.
REQ-032: rdata SHALL be unchanged by write transactions.

Reset
REQ-033: reset high at a rising edge SHALL force state IDLE, last_grant = B (A wins first tie), WR counter 0.
REQ-034: reset SHALL clear a_ack, b_ack, a_rdata, b_rdata, mem_addr, mem_din to 0 and mem_write to 2'b00.
REQ-035: reset mid-transaction SHALL abort it without ack; mem_write SHALL be 2'b00 from the cycle after the reset edge.

Verification
REQ-036: Reset then idle 5 cycles -> all outputs 0, mem_write 2'b00, no ack.
REQ-037: A write addr 4, data 20 -> mem_write 2'b10 for 2 cycles at mem_addr 4, mem_din 20; a_ack 3 cycles after grant; A read addr 4 -> a_ack 3 cycles after grant, a_rdata = 20.
REQ-038: A and B read same cycle after reset (A addr 1, B addr 2) -> A served first, B granted next IDLE; each rdata matches its address contents, acks never overlap.
REQ-039: A and B continuously re-request after each ack -> grants alternate A,B,A,B over 8 transactions.
REQ-040: B write, reset asserted in 1st WR cycle -> mem_write 2'b00 next cycle, b_ack never high, FSM in IDLE.
REQ-041: A changes a_addr 10->11 during RD_WAIT -> a_rdata = contents of addr 10.
